conv_window_ctrl: RTL and testbench

Line-buffering scheduler that sits in front of the 3x3 kernel engine (`conv33`). It accepts a raster-order single-channel pixel stream over a valid/ready handshake and stores rows in three rotating line buffers. Once a row is complete and two earlier rows exist, it bursts the three aligned rows into the engine at one column per clock, with no gaps. The engine has no clock enable, so all stalling is absorbed here; the block also tags the engine output with interior-pixel coordinates and a valid strobe.

---
 rtl/conv_window_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Line-buffering scheduler for the 3x3 kernel engine: stores raster rows in three
// rotating line buffers and bursts aligned column triples into the engine, tagging results.
module conv_window_ctrl #(
   parameter int PIXEL_WIDTH = 8,
   parameter int MAX_WIDTH   = 640,
   parameter int COL_W       = 10,
   parameter int ROW_W       = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [COL_W-1:0]       cfg_width,
   input  logic [ROW_W-1:0]       cfg_height,
   input  logic [1:0]             cfg_mode,
   input  logic                   in_valid,
   input  logic [PIXEL_WIDTH-1:0] in_pixel,
   output logic                   in_ready,
   output logic [PIXEL_WIDTH-1:0] pix_top,
   output logic [PIXEL_WIDTH-1:0] pix_mid,
   output logic [PIXEL_WIDTH-1:0] pix_bot,
   output logic [1:0]             kernel_mode,
   output logic                   out_valid,
   output logic [COL_W-1:0]       out_col,
   output logic [ROW_W-1:0]       out_row,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [1:0] {IDLE, FILL, BURST, DRAIN} state_t;

   state_t                 state;
   logic [COL_W-1:0]       width;
   logic [ROW_W-1:0]       height;
   logic [COL_W-1:0]       col;
   logic [ROW_W-1:0]       row;
   logic [1:0]             wr_sel;
   logic [1:0]             drain_cnt;

   // Tag stage aligned with the column currently on pix_*.
   logic                   tag_valid;
   logic [COL_W-1:0]       tag_col;
   logic [ROW_W-1:0]       tag_row;

   logic [PIXEL_WIDTH-1:0] line_buf [3][MAX_WIDTH];

   logic                   cfg_ok;
   logic                   accept;
   logic                   last_col;
   logic [1:0]             sel_next;
   logic [1:0]             sel_prev;
   logic [PIXEL_WIDTH-1:0] rd_top;
   logic [PIXEL_WIDTH-1:0] rd_mid;
   logic [PIXEL_WIDTH-1:0] rd_bot;

   assign cfg_ok   = (cfg_width >= COL_W'(3)) && (cfg_width <= COL_W'(MAX_WIDTH))
                     && (cfg_height >= ROW_W'(3));
   assign accept   = (state == FILL) && in_valid && in_ready;
   assign last_col = (col == width - COL_W'(1));

   // The buffer being written holds the newest row; the next one in rotation the oldest.
   always_comb begin
      sel_next = (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
      sel_prev = (wr_sel == 2'd0) ? 2'd2 : wr_sel - 2'd1;
   end

   assign rd_top = line_buf[sel_next][col];
   assign rd_mid = line_buf[sel_prev][col];
   assign rd_bot = line_buf[wr_sel][col];

   // NOTE: line-buffer storage has no reset; every location is written before it is read.
   always_ff @(posedge clk) begin
      if (accept) line_buf[wr_sel][col] <= in_pixel;
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         width       <= '0;
         height      <= '0;
         col         <= '0;
         row         <= '0;
         wr_sel      <= '0;
         drain_cnt   <= '0;
         tag_valid   <= 1'b0;
         tag_col     <= '0;
         tag_row     <= '0;
         in_ready    <= 1'b0;
         pix_top     <= '0;
         pix_mid     <= '0;
         pix_bot     <= '0;
         kernel_mode <= '0;
         out_valid   <= 1'b0;
         out_col     <= '0;
         out_row     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         tag_valid <= 1'b0;
         tag_col   <= '0;
         tag_row   <= '0;
         pix_top   <= '0;
         pix_mid   <= '0;
         pix_bot   <= '0;
         out_valid <= tag_valid;
         out_col   <= tag_col;
         out_row   <= tag_row;

         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     width       <= cfg_width;
                     height      <= cfg_height;
                     kernel_mode <= cfg_mode;
                     col         <= '0;
                     row         <= '0;
                     wr_sel      <= '0;
                     in_ready    <= 1'b1;
                     busy        <= 1'b1;
                     state       <= FILL;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            FILL: begin
               if (accept) begin
                  if (last_col) begin
                     col <= '0;
                     if (row < ROW_W'(2)) begin
                        row    <= row + ROW_W'(1);
                        wr_sel <= sel_next;
                     end else begin
                        in_ready <= 1'b0;
                        state    <= BURST;
                     end
                  end else begin
                     col <= col + COL_W'(1);
                  end
               end
            end

            BURST: begin
               pix_top   <= rd_top;
               pix_mid   <= rd_mid;
               pix_bot   <= rd_bot;
               tag_valid <= (col >= COL_W'(2));
               tag_col   <= col - COL_W'(1);
               tag_row   <= row - ROW_W'(1);
               if (last_col) begin
                  col <= '0;
                  if (row == height - ROW_W'(1)) begin
                     drain_cnt <= '0;
                     state     <= DRAIN;
                  end else begin
                     row      <= row + ROW_W'(1);
                     wr_sel   <= sel_next;
                     in_ready <= 1'b1;
                     state    <= FILL;
                  end
               end else begin
                  col <= col + COL_W'(1);
               end
            end

            DRAIN: begin
               // Two flush cycles let the tag pipeline empty; done follows, then IDLE.
               drain_cnt <= drain_cnt + 2'd1;
               if (drain_cnt == 2'd1) done <= 1'b1;
               if (drain_cnt == 2'd2) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: per-cycle output log plus per-scenario checks
// against hand-derived burst timing, column feed values and result coordinates.
module tb_conv_window_ctrl;

   localparam int PW  = 8;
   localparam int MW  = 640;
   localparam int CW  = 10;
   localparam int RW  = 10;
   localparam int LOG = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_width = '0;
   logic [RW-1:0] cfg_height = '0;
   logic [1:0]    cfg_mode = '0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_pixel = '0;
   logic          in_ready;
   logic [PW-1:0] pix_top, pix_mid, pix_bot;
   logic [1:0]    kernel_mode;
   logic          out_valid;
   logic [CW-1:0] out_col;
   logic [RW-1:0] out_row;
   logic          busy, done, err;

   conv_window_ctrl #(.PIXEL_WIDTH(PW), .MAX_WIDTH(MW), .COL_W(CW), .ROW_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .cfg_mode(cfg_mode), .in_valid(in_valid),
      .in_pixel(in_pixel), .in_ready(in_ready), .pix_top(pix_top), .pix_mid(pix_mid),
      .pix_bot(pix_bot), .kernel_mode(kernel_mode), .out_valid(out_valid),
      .out_col(out_col), .out_row(out_row), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [PW-1:0] top_l [LOG];
   logic [PW-1:0] mid_l [LOG];
   logic [PW-1:0] bot_l [LOG];
   logic          ov_l [LOG];
   logic          rdy_l [LOG];
   logic          busy_l [LOG];
   logic          done_l [LOG];
   logic          err_l [LOG];
   int            col_l [LOG];
   int            row_l [LOG];

   always @(negedge clk) begin
      if (cyc < LOG) begin
         top_l[cyc]  <= pix_top;
         mid_l[cyc]  <= pix_mid;
         bot_l[cyc]  <= pix_bot;
         ov_l[cyc]   <= out_valid;
         rdy_l[cyc]  <= in_ready;
         busy_l[cyc] <= busy;
         done_l[cyc] <= done;
         err_l[cyc]  <= err;
         col_l[cyc]  <= int'(out_col);
         row_l[cyc]  <= int'(out_row);
      end
   end

   int bursts[$];
   int ov_cyc[$];
   int ov_col[$];
   int ov_row[$];
   int done_cyc[$];
   int err_cnt;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] pval(input int pat, input int r, input int c);
      return (pat == 0) ? 8'd16 : 8'(10 * r + c);
   endfunction

   // Extracts burst starts, tagged results and done pulses from the log window [a, b).
   task automatic scan(input int a, input int b);
      bursts.delete(); ov_cyc.delete(); ov_col.delete(); ov_row.delete(); done_cyc.delete();
      err_cnt = 0;
      for (int c = a + 1; c < b; c++) begin
         if (busy_l[c - 1] && rdy_l[c - 1] && !rdy_l[c]) bursts.push_back(c);
         if (ov_l[c]) begin
            ov_cyc.push_back(c);
            ov_col.push_back(col_l[c]);
            ov_row.push_back(row_l[c]);
         end
         if (done_l[c]) done_cyc.push_back(c);
         if (err_l[c]) err_cnt++;
      end
   endtask

   task automatic run_frame(input int w, input int h, input int mode, input int pat,
                            input bit gaps, input int poke_at, output int t0, output int t1);
      int  idx, n;
      bit  tog, acc, poked;
      t0 = cyc;
      start = 1'b1; cfg_width = CW'(w); cfg_height = RW'(h); cfg_mode = 2'(mode);
      tick;
      start = 1'b0;
      idx = 0; n = 0; tog = 1'b0; poked = 1'b0;
      while (idx < w * h && n < 4000) begin
         acc = 1'b0;
         if (gaps && tog) in_valid = 1'b0;
         else if (in_ready) begin
            in_valid = 1'b1;
            in_pixel = pval(pat, idx / w, idx % w);
            acc = 1'b1;
         end else in_valid = 1'b0;
         if (!poked && idx == poke_at && acc) begin
            start = 1'b1; cfg_width = CW'(5); cfg_height = RW'(5); cfg_mode = 2'd3;
            poked = 1'b1;
         end
         tog = !tog;
         tick;
         start = 1'b0;
         if (acc) idx++;
         n++;
      end
      in_valid = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         tick;
         n++;
      end
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL frame_done_timeout got done=%b want 1 (w=%0d h=%0d)", done, w, h);
      end
      tick;
      tick;
      t1 = cyc;
   endtask

   task automatic test_reset;
      tests_run++;
      if ({in_ready, busy, done, err, out_valid} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got %b want 00000", {in_ready, busy, done, err, out_valid});
      end
      tests_run++;
      if ({pix_top, pix_mid, pix_bot} !== 24'h0) begin
         tests_failed++;
         $display("FAIL reset_pix got %h want 000000", {pix_top, pix_mid, pix_bot});
      end
      tests_run++;
      if ({kernel_mode, out_col, out_row} !== 22'h0) begin
         tests_failed++;
         $display("FAIL reset_tags got %h want 0", {kernel_mode, out_col, out_row});
      end
      rst_n = 1'b1;
      tick;
      tick;
      tests_run++;
      if ({busy, in_ready} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_idle got busy,in_ready=%b want 00", {busy, in_ready});
      end
   endtask

   task automatic test_basic;
      int t0, t1;
      int exp_col[4] = '{1, 2, 1, 2};
      int exp_row[4] = '{1, 1, 2, 2};
      int low;
      run_frame(4, 4, 1, 0, 1'b0, -1, t0, t1);
      scan(t0, t1);
      tests_run++;
      if (bursts.size() !== 2) begin
         tests_failed++;
         $display("FAIL basic_bursts got %0d want 2", bursts.size());
      end
      tests_run++;
      if (ov_cyc.size() !== 4) begin
         tests_failed++;
         $display("FAIL basic_ov_count got %0d want 4", ov_cyc.size());
      end
      for (int k = 0; k < 4 && k < ov_cyc.size() && bursts.size() == 2; k++) begin
         tests_run++;
         if (ov_col[k] !== exp_col[k] || ov_row[k] !== exp_row[k]
             || ov_cyc[k] !== bursts[k / 2] + 4 + (k % 2)) begin
            tests_failed++;
            $display("FAIL basic_result%0d got (r%0d,c%0d)@%0d want (r%0d,c%0d)@%0d", k,
                     ov_row[k], ov_col[k], ov_cyc[k], exp_row[k], exp_col[k],
                     bursts[k / 2] + 4 + (k % 2));
         end
         tests_run++;
         if ({top_l[ov_cyc[k] - 1], mid_l[ov_cyc[k] - 1], bot_l[ov_cyc[k] - 1]} !== 24'h101010) begin
            tests_failed++;
            $display("FAIL basic_feed%0d got %h want 101010", k,
                     {top_l[ov_cyc[k] - 1], mid_l[ov_cyc[k] - 1], bot_l[ov_cyc[k] - 1]});
         end
      end
      if (bursts.size() == 2) begin
         low = 0;
         for (int j = 0; j < 4; j++) if (!rdy_l[bursts[0] + j]) low++;
         tests_run++;
         if (low !== 4 || rdy_l[bursts[0] + 4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready_gap got low=%0d ready_after=%b want 4,1", low,
                     rdy_l[bursts[0] + 4]);
         end
         tests_run++;
         if (done_cyc.size() !== 1 || done_cyc[0] !== bursts[1] + 6) begin
            tests_failed++;
            $display("FAIL basic_done got %0d pulses first@%0d want 1 @%0d", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1, bursts[1] + 6);
         end
         tests_run++;
         if (busy_l[bursts[1] + 7] !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy_end got %b want 0", busy_l[bursts[1] + 7]);
         end
      end
      tests_run++;
      if (kernel_mode !== 2'd1) begin
         tests_failed++;
         $display("FAIL basic_mode got %0d want 1", kernel_mode);
      end
   endtask

   // Shared by the contiguous and gapped runs of the 5x3 ramp frame.
   task automatic check_ramp_5x3(input string tag, input int t0, input int t1);
      int b, low;
      scan(t0, t1);
      tests_run++;
      if (bursts.size() !== 1) begin
         tests_failed++;
         $display("FAIL %s_bursts got %0d want 1", tag, bursts.size());
         return;
      end
      b = bursts[0];
      tests_run++;
      if ({top_l[b], mid_l[b], bot_l[b]} !== 24'h0) begin
         tests_failed++;
         $display("FAIL %s_pre_burst got %h want 000000", tag, {top_l[b], mid_l[b], bot_l[b]});
      end
      for (int j = 0; j < 5; j++) begin
         tests_run++;
         if ({top_l[b + 1 + j], mid_l[b + 1 + j], bot_l[b + 1 + j]}
             !== {pval(1, 0, j), pval(1, 1, j), pval(1, 2, j)}) begin
            tests_failed++;
            $display("FAIL %s_col%0d got %0d/%0d/%0d want %0d/%0d/%0d", tag, j,
                     top_l[b + 1 + j], mid_l[b + 1 + j], bot_l[b + 1 + j], j, 10 + j, 20 + j);
         end
      end
      tests_run++;
      if ({top_l[b + 6], mid_l[b + 6], bot_l[b + 6]} !== 24'h0) begin
         tests_failed++;
         $display("FAIL %s_post_burst got %h want 000000", tag,
                  {top_l[b + 6], mid_l[b + 6], bot_l[b + 6]});
      end
      low = 0;
      for (int j = 0; j < 5; j++) if (!rdy_l[b + j]) low++;
      tests_run++;
      if (low !== 5) begin
         tests_failed++;
         $display("FAIL %s_ready_low got %0d want 5", tag, low);
      end
      tests_run++;
      if (ov_cyc.size() !== 3) begin
         tests_failed++;
         $display("FAIL %s_ov_count got %0d want 3", tag, ov_cyc.size());
      end
      for (int k = 0; k < 3 && k < ov_cyc.size(); k++) begin
         tests_run++;
         if (ov_cyc[k] !== b + 4 + k || ov_col[k] !== k + 1 || ov_row[k] !== 1) begin
            tests_failed++;
            $display("FAIL %s_result%0d got (r%0d,c%0d)@%0d want (r1,c%0d)@%0d", tag, k,
                     ov_row[k], ov_col[k], ov_cyc[k], k + 1, b + 4 + k);
         end
      end
      tests_run++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== b + 7) begin
         tests_failed++;
         $display("FAIL %s_done got %0d pulses first@%0d want 1 @%0d", tag, done_cyc.size(),
                  (done_cyc.size() > 0) ? done_cyc[0] : -1, b + 7);
      end
   endtask

   task automatic test_burst_alignment;
      int t0, t1;
      run_frame(5, 3, 0, 1, 1'b0, -1, t0, t1);
      check_ramp_5x3("align", t0, t1);
   endtask

   task automatic test_input_gaps;
      int t0, t1;
      run_frame(5, 3, 0, 1, 1'b1, -1, t0, t1);
      check_ramp_5x3("gaps", t0, t1);
   endtask

   task automatic test_min_frame;
      int t0, t1;
      run_frame(3, 3, 2, 1, 1'b0, -1, t0, t1);
      scan(t0, t1);
      tests_run++;
      if (bursts.size() !== 1 || ov_cyc.size() !== 1) begin
         tests_failed++;
         $display("FAIL min_counts got bursts=%0d ov=%0d want 1,1", bursts.size(), ov_cyc.size());
      end else begin
         tests_run++;
         if (ov_cyc[0] !== bursts[0] + 4 || ov_col[0] !== 1 || ov_row[0] !== 1) begin
            tests_failed++;
            $display("FAIL min_result got (r%0d,c%0d)@%0d want (r1,c1)@%0d", ov_row[0],
                     ov_col[0], ov_cyc[0], bursts[0] + 4);
         end
      end
   endtask

   task automatic test_config_reject;
      int ws[3] = '{2, 700, 640};
      int hs[3] = '{5, 1000, 2};
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; cfg_width = CW'(ws[i]); cfg_height = RW'(hs[i]); cfg_mode = 2'd3;
         tick;
         start = 1'b0;
         tests_run++;
         if ({err, busy, in_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reject%0d_pulse got err,busy,rdy=%b want 100", i, {err, busy, in_ready});
         end
         tick;
         tests_run++;
         if ({err, busy, in_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reject%0d_after got err,busy,rdy=%b want 000", i, {err, busy, in_ready});
         end
      end
      // Widest legal line is accepted; abort it with reset afterwards.
      start = 1'b1; cfg_width = CW'(MW); cfg_height = RW'(3); cfg_mode = 2'd2;
      tick;
      start = 1'b0;
      tests_run++;
      if ({err, busy, in_ready} !== 3'b011) begin
         tests_failed++;
         $display("FAIL accept_max got err,busy,rdy=%b want 011", {err, busy, in_ready});
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_start_while_busy;
      int t0, t1;
      run_frame(4, 4, 2, 0, 1'b0, 6, t0, t1);
      scan(t0, t1);
      tests_run++;
      if (kernel_mode !== 2'd2) begin
         tests_failed++;
         $display("FAIL busy_start_mode got %0d want 2", kernel_mode);
      end
      tests_run++;
      if (ov_cyc.size() !== 4 || bursts.size() !== 2) begin
         tests_failed++;
         $display("FAIL busy_start_counts got ov=%0d bursts=%0d want 4,2", ov_cyc.size(),
                  bursts.size());
      end
      tests_run++;
      if (err_cnt !== 0) begin
         tests_failed++;
         $display("FAIL busy_start_err got %0d pulses want 0", err_cnt);
      end
   endtask

   task automatic test_reset_mid_burst;
      int idx, n, t0, t1;
      start = 1'b1; cfg_width = CW'(4); cfg_height = RW'(4); cfg_mode = 2'd1;
      tick;
      start = 1'b0;
      idx = 0; n = 0;
      while (idx < 12 && n < 100) begin
         in_valid = in_ready;
         in_pixel = 8'd16;
         tick;
         if (in_valid) idx++;
         n++;
      end
      in_valid = 1'b0;
      tick;
      tests_run++;
      if (pix_top !== 8'd16) begin
         tests_failed++;
         $display("FAIL rst_burst_active got pix_top=%0d want 16", pix_top);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({in_ready, busy, done, err, out_valid, kernel_mode} !== 7'b0) begin
         tests_failed++;
         $display("FAIL rst_async_ctrl got %b want 0", {in_ready, busy, done, err, out_valid, kernel_mode});
      end
      tests_run++;
      if ({pix_top, pix_mid, pix_bot, out_col, out_row} !== 44'h0) begin
         tests_failed++;
         $display("FAIL rst_async_data got %h want 0", {pix_top, pix_mid, pix_bot, out_col, out_row});
      end
      tick;
      rst_n = 1'b1;
      tick;
      run_frame(4, 4, 1, 0, 1'b0, -1, t0, t1);
      scan(t0, t1);
      tests_run++;
      if (ov_cyc.size() !== 4) begin
         tests_failed++;
         $display("FAIL rst_refresh_count got %0d want 4", ov_cyc.size());
      end
      for (int k = 0; k < 4 && k < ov_cyc.size(); k++) begin
         tests_run++;
         if (ov_row[k] !== 1 + k / 2 || ov_col[k] !== 1 + k % 2) begin
            tests_failed++;
            $display("FAIL rst_refresh_result%0d got (r%0d,c%0d) want (r%0d,c%0d)", k,
                     ov_row[k], ov_col[k], 1 + k / 2, 1 + k % 2);
         end
      end
   endtask

   initial begin
      tick;
      tick;
      test_reset;
      test_basic;
      test_burst_alignment;
      test_input_gaps;
      test_min_frame;
      test_config_reject;
      test_start_while_busy;
      test_reset_mid_burst;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
